// File: rtl/bpm_tap_detector.sv
// Tap-tempo front end. It synchronises the tap button, measures the clk interval
// between accepted taps, and converts that interval to BPM with a serial divider.
module bpm_tap_detector #(
  parameter longint CLK_FREQ = 100_000_000,
  parameter int     BPM_MIN  = 30,
  parameter int     BPM_MAX  = 240,
  parameter int     BPM_W    = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tap,
  output logic [BPM_W-1:0] bpm,
  output logic             bpm_valid,
  output logic             locked,
  output logic             beat,
  output logic             busy
);

  localparam logic [33:0] DIVIDEND   = 34'(CLK_FREQ * 60);
  localparam logic [33:0] MIN_PERIOD = 34'(CLK_FREQ * 60 / BPM_MAX);
  localparam logic [33:0] MAX_PERIOD = 34'(CLK_FREQ * 60 / BPM_MIN);

  typedef enum logic {IDLE, MEASURE} state_t;
  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} dstate_t;

  // sync_q[0..1] is the two-flop synchroniser, sync_q[2] holds the previous level
  logic [2:0]  sync_q;
  logic        tap_rise;
  state_t      state, state_n;
  logic [33:0] cnt, cnt_n, cnt_inc;
  logic        start;
  dstate_t     dstate, dstate_n;
  logic [33:0] divisor, rem, dq;
  logic [5:0]  iter;
  logic [34:0] trial;
  logic        ge;
  logic [33:0] rem_n, q_n;

  // Synchronise the async tap and register a single-cycle rising-edge pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      tap_rise <= 1'b0;
    end else begin
      sync_q   <= {sync_q[1:0], tap};
      tap_rise <= sync_q[1] & ~sync_q[2];
    end
  end

  assign cnt_inc = cnt + 34'd1;

  // Measurement FSM state and interval counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Accept/reject/timeout decisions; a tap wins over a simultaneous timeout
  always_comb begin
    state_n = state;
    cnt_n   = cnt_inc;
    beat    = 1'b0;
    start   = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (tap_rise) begin
          state_n = MEASURE;
          beat    = 1'b1;
        end
      end
      MEASURE: begin
        if (tap_rise && cnt_inc >= MIN_PERIOD) begin
          beat  = 1'b1;
          start = 1'b1;
          cnt_n = '0;
        end else if (!tap_rise && cnt_inc == MAX_PERIOD) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign locked = (state == MEASURE);

  // One restoring step: shift the next dividend bit into the partial remainder
  assign trial = {rem, dq[33]};
  assign ge    = (trial >= {1'b0, divisor});
  assign rem_n = ge ? 34'(trial - {1'b0, divisor}) : trial[33:0];
  assign q_n   = {dq[32:0], ge};

  // Divider sequencing: 34 iterations, then one DONE cycle that publishes bpm
  always_comb begin
    dstate_n = dstate;
    case (dstate)
      DIV_IDLE: if (start) dstate_n = DIV_RUN;
      DIV_RUN:  if (iter == 6'd33) dstate_n = DIV_DONE;
      DIV_DONE: dstate_n = DIV_IDLE;
      default:  dstate_n = DIV_IDLE;
    endcase
  end

  // Divider state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dstate <= DIV_IDLE;
    else     dstate <= dstate_n;
  end

  // Divider datapath; dq holds remaining dividend bits and accumulates the quotient
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divisor <= '0;
      rem     <= '0;
      dq      <= '0;
      iter    <= '0;
      bpm     <= '0;
    end else if (dstate == DIV_IDLE && start) begin
      divisor <= cnt_inc;
      rem     <= '0;
      dq      <= DIVIDEND;
      iter    <= '0;
    end else if (dstate == DIV_RUN) begin
      rem  <= rem_n;
      dq   <= q_n;
      iter <= iter + 6'd1;
      if (iter == 6'd33) bpm <= q_n[BPM_W-1:0];
    end
  end

  assign bpm_valid = (dstate == DIV_DONE);
  assign busy      = (dstate != DIV_IDLE);

endmodule
